// File: rtl/note_pkg.sv
// Shared types and constants for the keypad note path: note code layout,
// scanner state encoding and the note-code packing helper.
package note_pkg;

    localparam logic [7:0] NOTE_NONE        = 8'h00;
    localparam int         NOTE_PRESSED_BIT = 7;
    localparam int         NOTE_IDX_MSB     = 3;
    localparam int         NOTE_IDX_LSB     = 0;

    typedef logic [7:0] note_code_t;

    typedef enum logic [1:0] {
        DRIVE  = 2'd0,
        SAMPLE = 2'd1,
        EVAL   = 2'd2
    } scan_state_e;

    function automatic note_code_t make_note(input logic valid, input logic [3:0] idx);
        note_code_t code;
        code = NOTE_NONE;
        if (valid) begin
            code[NOTE_PRESSED_BIT]          = 1'b1;
            code[NOTE_IDX_MSB:NOTE_IDX_LSB] = idx;
        end else begin
            code = NOTE_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Frame-rate debouncer: a candidate {valid,idx} must repeat DEBOUNCE_SCANS
// evaluations in a row before it replaces the committed note code.
module key_debouncer
    import note_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       eval,
    input  logic       raw_valid,
    input  logic [3:0] raw_idx,
    output logic [7:0] note_code,
    output logic       key_event
);

    localparam int             CW         = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0]  STABLE_MAX = CW'(DEBOUNCE_SCANS);

    logic [4:0]    cand_q, cand_d;
    logic [CW-1:0] stable_q, stable_d;
    note_code_t    note_code_q, note_code_d;
    logic          key_event_q, key_event_d;
    logic [4:0]    raw_s;
    note_code_t    raw_code_s;

    assign raw_s      = {raw_valid, raw_idx};
    assign raw_code_s = make_note(raw_valid, raw_idx);

    // Candidate tracking, saturating stability count and commit decision.
    always_comb begin
        cand_d      = cand_q;
        stable_d    = stable_q;
        note_code_d = note_code_q;
        key_event_d = 1'b0;
        if (eval) begin
            if (raw_s == cand_q) begin
                if (stable_q != STABLE_MAX) begin
                    stable_d = stable_q + CW'(1);
                end else begin
                    stable_d = stable_q;
                end
            end else begin
                cand_d   = raw_s;
                stable_d = CW'(1);
            end
            // Only a release-to-press or key-to-key transition raises the event.
            if ((stable_d == STABLE_MAX) && (raw_code_s != note_code_q)) begin
                note_code_d = raw_code_s;
                key_event_d = raw_valid;
            end else begin
                note_code_d = note_code_q;
                key_event_d = 1'b0;
            end
        end else begin
            cand_d      = cand_q;
            stable_d    = stable_q;
            note_code_d = note_code_q;
            key_event_d = 1'b0;
        end
    end

    // Debounce state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q      <= 5'd0;
            stable_q    <= '0;
            note_code_q <= NOTE_NONE;
            key_event_q <= 1'b0;
        end else begin
            cand_q      <= cand_d;
            stable_q    <= stable_d;
            note_code_q <= note_code_d;
            key_event_q <= key_event_d;
        end
    end

    assign note_code = note_code_q;
    assign key_event = key_event_q;

endmodule

// File: rtl/note_key_scanner.sv
// 4x4 active-low keypad scanner: drives one column at a time, assembles a
// 16-bit frame of pressed keys, resolves the lowest index and debounces it.
module note_key_scanner
    import note_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [7:0] note_code,
    output logic       key_event
);

    localparam int            DW         = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 2);

    logic [3:0]  row_meta_q, row_sync_q;
    scan_state_e state_q, state_d;
    logic [1:0]  col_idx_q, col_idx_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [15:0] frame_q, frame_d;
    logic [3:0]  col_n_q, col_n_d;
    logic        raw_valid_s;
    logic [3:0]  raw_idx_s;
    logic        eval_s;

    // Two-flop synchronizer; idle rows read as released (pulled high).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= row_n;
            row_sync_q <= row_meta_q;
        end
    end

    // Scan sequencing; column drive is registered, so pins trail the state by one cycle.
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        dwell_d   = dwell_q;
        frame_d   = frame_q;
        col_n_d   = 4'hF;
        case (state_q)
            DRIVE: begin
                col_n_d = ~(4'b0001 << col_idx_q);
                dwell_d = dwell_q + DW'(1);
                if (dwell_q == DWELL_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    state_d = DRIVE;
                end
            end
            SAMPLE: begin
                col_n_d = ~(4'b0001 << col_idx_q);
                dwell_d = '0;
                frame_d[{col_idx_q, 2'b00} +: 4] = ~row_sync_q;
                if (col_idx_q != 2'd3) begin
                    col_idx_d = col_idx_q + 2'd1;
                    state_d   = DRIVE;
                end else begin
                    state_d   = EVAL;
                end
            end
            EVAL: begin
                col_n_d   = 4'hF;
                dwell_d   = '0;
                col_idx_d = 2'd0;
                state_d   = DRIVE;
            end
            default: begin
                col_n_d   = 4'hF;
                dwell_d   = '0;
                col_idx_d = 2'd0;
                state_d   = DRIVE;
            end
        endcase
    end

    // Scan state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= DRIVE;
            col_idx_q <= 2'd0;
            dwell_q   <= '0;
            frame_q   <= 16'h0000;
            col_n_q   <= 4'hF;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            dwell_q   <= dwell_d;
            frame_q   <= frame_d;
            col_n_q   <= col_n_d;
        end
    end

    // Lowest pressed index wins when several keys are held.
    always_comb begin
        raw_valid_s = |frame_q;
        raw_idx_s   = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (frame_q[i]) begin
                raw_idx_s = 4'(i);
            end else begin
                raw_idx_s = raw_idx_s;
            end
        end
    end

    assign eval_s = (state_q == EVAL);

    key_debouncer #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debouncer (
        .clk       (clk),
        .rst_n     (reset_n),
        .eval      (eval_s),
        .raw_valid (raw_valid_s),
        .raw_idx   (raw_idx_s),
        .note_code (note_code),
        .key_event (key_event)
    );

    assign col_n = col_n_q;

endmodule

// File: tb/tb_note_key_scanner.sv
// Directed bench for note_key_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3) with a
// behavioural keypad; one frame is 17 cycles, cycle 0 is the reset-release cycle.
module tb_note_key_scanner;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [7:0]  note_code;
    logic        key_event;
    logic [15:0] keys;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int ev_cnt  = 0;
    int ev0     = 0;

    always #5 clk = ~clk;

    note_key_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .note_code (note_code),
        .key_event (key_event)
    );

    // Keypad: a held key connects its column drive to its row line.
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keys[c*4 + r] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (key_event === 1'b1) ev_cnt++;
    end

    task automatic goto(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic start(input logic [15:0] k);
        reset_n = 1'b0;
        keys    = k;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        keys    = 16'h0001;
        repeat (3) @(negedge clk);
        vectors++;
        if (col_n !== 4'hF) begin errors++; $display("FAIL reset_col_n: got %h expected F", col_n); end
        vectors++;
        if (note_code !== 8'h00) begin errors++; $display("FAIL reset_note: got %h expected 00", note_code); end
        vectors++;
        if (key_event !== 1'b0) begin errors++; $display("FAIL reset_event: got %b expected 0", key_event); end
    endtask

    task automatic test_scan_order();
        logic [3:0] exp_col;
        int p;
        start(16'h0000);
        ev0 = ev_cnt;
        for (int t = 0; t < 34; t++) begin
            goto(t);
            p = t % 17;
            if (p == 0) exp_col = 4'hF;
            else        exp_col = ~(4'b0001 << ((p - 1) / 4));
            vectors++;
            if (col_n !== exp_col) begin
                errors++;
                $display("FAIL scan_col_n t=%0d: got %h expected %h", t, col_n, exp_col);
            end
        end
        goto(70);
        vectors++;
        if (note_code !== 8'h00) begin errors++; $display("FAIL scan_idle_note: got %h expected 00", note_code); end
        vectors++;
        if (ev_cnt - ev0 != 0) begin errors++; $display("FAIL scan_no_event: got %0d events expected 0", ev_cnt - ev0); end
    endtask

    task automatic test_clean_press();
        start(16'h0200);
        ev0 = ev_cnt;
        goto(50);
        vectors++;
        if (note_code !== 8'h00) begin errors++; $display("FAIL press_early: got %h expected 00", note_code); end
        goto(51);
        vectors++;
        if (note_code !== 8'h89) begin errors++; $display("FAIL press_note: got %h expected 89", note_code); end
        vectors++;
        if (key_event !== 1'b1) begin errors++; $display("FAIL press_event: got %b expected 1", key_event); end
        goto(52);
        vectors++;
        if (key_event !== 1'b0) begin errors++; $display("FAIL press_event_width: got %b expected 0", key_event); end
        for (int f = 1; f <= 5; f++) begin
            goto(51 + 17*f);
            vectors++;
            if (note_code !== 8'h89) begin errors++; $display("FAIL press_hold f=%0d: got %h expected 89", f, note_code); end
        end
        vectors++;
        if (ev_cnt - ev0 != 1) begin errors++; $display("FAIL press_event_count: got %0d expected 1", ev_cnt - ev0); end
    endtask

    task automatic test_bounce();
        start(16'h0200);
        ev0 = ev_cnt;
        for (int f = 1; f <= 5; f++) begin
            goto(17*f);
            vectors++;
            if (note_code !== 8'h00) begin errors++; $display("FAIL bounce_note f=%0d: got %h expected 00", f, note_code); end
            keys = (f % 2 == 0) ? 16'h0200 : 16'h0000;
        end
        goto(170);
        vectors++;
        if (note_code !== 8'h00) begin errors++; $display("FAIL bounce_final: got %h expected 00", note_code); end
        vectors++;
        if (ev_cnt - ev0 != 0) begin errors++; $display("FAIL bounce_events: got %0d expected 0", ev_cnt - ev0); end
    endtask

    task automatic test_release_repress();
        start(16'h0200);
        goto(51);
        vectors++;
        if (note_code !== 8'h89) begin errors++; $display("FAIL rr_first: got %h expected 89", note_code); end
        keys = 16'h0000;
        goto(52);
        ev0 = ev_cnt;
        goto(101);
        vectors++;
        if (note_code !== 8'h89) begin errors++; $display("FAIL rr_still_held: got %h expected 89", note_code); end
        goto(102);
        vectors++;
        if (note_code !== 8'h00) begin errors++; $display("FAIL rr_release: got %h expected 00", note_code); end
        vectors++;
        if (key_event !== 1'b0) begin errors++; $display("FAIL rr_release_event: got %b expected 0", key_event); end
        keys = 16'h0200;
        goto(152);
        vectors++;
        if (note_code !== 8'h00) begin errors++; $display("FAIL rr_repress_early: got %h expected 00", note_code); end
        goto(153);
        vectors++;
        if (note_code !== 8'h89) begin errors++; $display("FAIL rr_repress: got %h expected 89", note_code); end
        vectors++;
        if (key_event !== 1'b1) begin errors++; $display("FAIL rr_repress_event: got %b expected 1", key_event); end
        goto(155);
        vectors++;
        if (ev_cnt - ev0 != 1) begin errors++; $display("FAIL rr_event_count: got %0d expected 1", ev_cnt - ev0); end
    endtask

    task automatic test_multi_direct();
        start(16'h1020);
        goto(51);
        vectors++;
        if (note_code !== 8'h85) begin errors++; $display("FAIL multi_lowest: got %h expected 85", note_code); end
        keys = 16'h1000;
        goto(52);
        ev0 = ev_cnt;
        goto(101);
        vectors++;
        if (note_code !== 8'h85) begin errors++; $display("FAIL direct_early: got %h expected 85", note_code); end
        goto(102);
        vectors++;
        if (note_code !== 8'h8C) begin errors++; $display("FAIL direct_note: got %h expected 8C", note_code); end
        vectors++;
        if (key_event !== 1'b1) begin errors++; $display("FAIL direct_event: got %b expected 1", key_event); end
        goto(104);
        vectors++;
        if (ev_cnt - ev0 != 1) begin errors++; $display("FAIL direct_event_count: got %0d expected 1", ev_cnt - ev0); end
    endtask

    task automatic test_reset_mid();
        start(16'h0001);
        goto(40);
        ev0 = ev_cnt;
        reset_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (note_code !== 8'h00) begin errors++; $display("FAIL midrst_note: got %h expected 00", note_code); end
        vectors++;
        if (col_n !== 4'hF) begin errors++; $display("FAIL midrst_col_n: got %h expected F", col_n); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
        goto(50);
        vectors++;
        if (note_code !== 8'h00) begin errors++; $display("FAIL midrst_early: got %h expected 00", note_code); end
        goto(51);
        vectors++;
        if (note_code !== 8'h80) begin errors++; $display("FAIL midrst_note_after: got %h expected 80", note_code); end
        vectors++;
        if (key_event !== 1'b1) begin errors++; $display("FAIL midrst_event: got %b expected 1", key_event); end
        goto(53);
        vectors++;
        if (ev_cnt - ev0 != 1) begin errors++; $display("FAIL midrst_event_count: got %0d expected 1", ev_cnt - ev0); end
    endtask

    initial begin
        reset_n = 1'b0;
        keys    = 16'h0000;
        test_reset();
        test_scan_order();
        test_clean_press();
        test_bounce();
        test_release_repress();
        test_multi_direct();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
